ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of ICache. It owns the PC and issues sequential read requests to the cache. Returned instructions are tagged with their PC and buffered in a small FIFO feeding decode through a valid/ready handshake. It also handles redirects (branch/exception) that arrive while a cache miss is in flight.

Parameters:
RESET_PC, InstAddr'(0), PC loaded on reset.
PC_STEP, 1, PC increment per instruction, in InstAddr units.
DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_redirect  in  1  load new PC and flush; single-cycle pulse
i_redirect_pc  in  $size(InstAddr)  redirect target
o_cache_addr  out  $size(InstAddr)  to ICache i_addr
o_cache_rd  out  1  to ICache i_rd
i_cache_inst  in  $size(Inst)  from ICache o_inst
i_cache_busy  in  1  from ICache o_busy
i_cache_hit  in  1  from ICache o_hit; used only by the perf option
o_valid  out  1  FIFO head valid
o_inst  out  $size(Inst)  head instruction
o_pc  out  $size(InstAddr)  head PC
i_ready  in  1  decode consumes head when o_valid&&i_ready
o_hit_count  out  32  perf: accepted hits
o_miss_count  out  32  perf: accepted misses

Behaviour:
- Reset: pc=RESET_PC, FIFO empty, state=FETCH.
  - o_valid=0, o_cache_rd=0, o_cache_addr=RESET_PC, counters=0.
- Cache contract:
  - rd/addr are held stable while i_cache_busy=1.
  - The response is accepted in a cycle where o_cache_rd=1 and i_cache_busy=0; i_cache_inst is valid combinationally in that cycle.
- o_cache_addr is always pc. No request is issued in the reset cycle itself.
- States:
  - FETCH: o_cache_rd=1 when the FIFO has space. Space = count<DEPTH, or count==DEPTH with a pop this cycle.
    - On accept: push {pc, i_cache_inst}; pc<=pc+PC_STEP (wraps modulo 2^$size(InstAddr)).
  - DRAIN: entered on redirect while i_cache_busy=1.
    - Keep o_cache_rd=1 at the old addr until busy=0, discard that response, then go to FETCH.
    - The old addr is held in a separate register; pc already holds the target.
- Redirect:
  - Takes priority over push and pop in the same cycle.
  - pc<=i_redirect_pc; FIFO flushed, so o_valid=0 the next cycle.
  - Any accept in the redirect cycle is discarded.
  - Redirect while in DRAIN updates the target and stays in DRAIN.
- FIFO:
  - Simultaneous push+pop keeps count unchanged, including when full or empty.
  - A pop with o_valid=0 is ignored.
  - o_inst/o_pc are registered head data: head→o_valid latency is 1 cycle after push.
- Fetch-to-decode latency on a hit: 1 cycle after accept.
- Reset mid-miss: the state machine returns to FETCH.
  - o_cache_rd=0 for the reset cycle; ICache is reset by the same signal.

Optional Feature:
IFETCH_PERF_EN:
- Defined: two 32-bit wrapping counters. They increment on each accepted, non-discarded response, by i_cache_hit (1 = hit, 0 = miss).
- Undefined: no counter flops; o_hit_count and o_miss_count are tied to 0.

Decomposition:
- Types package additions:
  - FetchState enum {FETCH, DRAIN}.
  - FetchEntry packed struct {InstAddr pc; Inst inst}.
  - Constant IFETCH_COUNT_W=32.
- Sub-module fetch_fifo: parameterised by DEPTH and a data type of FetchEntry.
  - Ports: push, pop, flush, full, empty, count.
  - Synchronous flush.

Test Plan:
- Release reset, i_ready=1, ROM all-hit after warm-up → sequential PCs 0x000, 0x001, 0x002… on o_pc, with o_inst matching ROM[pc].
- i_ready=0 for 20 cycles → exactly DEPTH=4 entries buffered, o_cache_rd drops to 0. Raise i_ready → PCs 0x000–0x003 drained in order, fetch resumes at 0x004.
- Redirect to 0x010 while busy=1 on a miss at 0x005 → stays in DRAIN until busy=0. The 0x005 inst never appears; next o_pc=0x010.
- Redirect to 0x012 on the same cycle as a push and a pop → FIFO empty next cycle; first output pc=0x012.
- pc=0xFFF with PC_STEP=1 → next request at 0x000.
- With IFETCH_PERF_EN: first fetch of 0x010 miss, refetch of 0x010 hit → miss_count=1, hit_count=1. Without the macro, both counters read 0.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_unit_pkg;

   localparam int unsigned INST_ADDR_W    = 12;
   localparam int unsigned INST_W         = 32;
   localparam int unsigned IFETCH_COUNT_W = 32;

   typedef logic [INST_ADDR_W-1:0] InstAddr;
   typedef logic [INST_W-1:0]      Inst;

   typedef enum logic {
      FETCH,
      DRAIN
   } FetchState;

   typedef struct packed {
      InstAddr pc;
      Inst     inst;
   } FetchEntry;

endpackage

// File: rtl/ifetch_unit_if.sv
// Cache request/response and decode valid/ready signals of the fetch unit.
interface ifetch_unit_if;
   import ifetch_unit_pkg::*;

   InstAddr o_cache_addr;
   logic    o_cache_rd;
   Inst     i_cache_inst;
   logic    i_cache_busy;
   logic    i_cache_hit;

   logic    o_valid;
   Inst     o_inst;
   InstAddr o_pc;
   logic    i_ready;

   modport master (
      output o_cache_addr, o_cache_rd, o_valid, o_inst, o_pc,
      input  i_cache_inst, i_cache_busy, i_cache_hit, i_ready
   );

   modport slave (
      input  o_cache_addr, o_cache_rd, o_valid, o_inst, o_pc,
      output i_cache_inst, i_cache_busy, i_cache_hit, i_ready
   );

endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// Small power-of-two FIFO of fetched entries with synchronous flush.
module fetch_fifo
   import ifetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type T = FetchEntry,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             push,
   input  T                 push_data,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output T                 head
);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Flush wins over any push or pop in the same cycle.
   always_ff @(posedge i_clock) begin
      if (i_reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, reads ICache sequentially, buffers tagged instructions for decode.
// Optional perf counters enabled by defining IFETCH_PERF_EN.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter InstAddr     RESET_PC = InstAddr'(0),
   parameter int unsigned PC_STEP  = 1,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_redirect,
   input  InstAddr                   i_redirect_pc,
   ifetch_unit_if.master             bus,
   output logic [IFETCH_COUNT_W-1:0] o_hit_count,
   output logic [IFETCH_COUNT_W-1:0] o_miss_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   FetchState        state_q;
   FetchState        state_d;
   InstAddr          pc_q;
   InstAddr          pc_d;
   InstAddr          drain_addr_q;
   InstAddr          drain_addr_d;
   logic             cache_rd_c;
   logic             push_c;
   logic             pop_req_c;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count_unused;
   FetchEntry        push_data;
   FetchEntry        head;

   assign pop_req_c = bus.o_valid && bus.i_ready;
   assign push_data = '{pc: pc_q, inst: bus.i_cache_inst};

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   // Request generation, PC update and redirect handling; reset cycle issues nothing.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      cache_rd_c   = 1'b0;
      push_c       = 1'b0;
      if (!i_reset) begin
         case (state_q)
            FETCH: begin
               cache_rd_c = !fifo_full || pop_req_c;
               if (i_redirect) begin
                  pc_d = i_redirect_pc;
                  if (cache_rd_c && bus.i_cache_busy) begin
                     state_d      = DRAIN;
                     drain_addr_d = pc_q;
                  end
               end else if (cache_rd_c && !bus.i_cache_busy) begin
                  push_c = 1'b1;
                  pc_d   = pc_q + InstAddr'(PC_STEP);
               end
            end
            DRAIN: begin
               // Old request must complete; its response is dropped.
               cache_rd_c = 1'b1;
               if (i_redirect) begin
                  pc_d = i_redirect_pc;
               end
               if (!bus.i_cache_busy) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   assign bus.o_cache_rd   = cache_rd_c;
   assign bus.o_cache_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (FetchEntry)
   ) u_fifo (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .push      (push_c),
      .push_data (push_data),
      .pop       (pop_req_c),
      .flush     (i_redirect),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused),
      .head      (head)
   );

   assign bus.o_valid = !fifo_empty;
   assign bus.o_pc    = head.pc;
   assign bus.o_inst  = head.inst;

`ifdef IFETCH_PERF_EN
   // Count only responses that actually entered the FIFO.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_hit_count  <= '0;
         o_miss_count <= '0;
      end else if (push_c) begin
         if (bus.i_cache_hit) begin
            o_hit_count <= o_hit_count + IFETCH_COUNT_W'(1);
         end else begin
            o_miss_count <= o_miss_count + IFETCH_COUNT_W'(1);
         end
      end
   end
`else
   logic unused_cache_hit;
   assign unused_cache_hit = bus.i_cache_hit;
   assign o_hit_count      = '0;
   assign o_miss_count     = '0;
`endif

endmodule
